// File: rtl/song_reader_pkg.sv
// Shared definitions for the song reader: datapath widths, FSM state
// encodings, ROM word layout and the built-in song table.
package song_reader_pkg;

  localparam int NOTE_W    = 6;               // note code width
  localparam int DUR_W     = 6;               // duration width
  localparam int IDX_W     = 5;               // note index width
  localparam int SONG_W    = 2;               // song select width
  localparam int ADDR_W    = SONG_W + IDX_W;  // ROM address {song, idx}
  localparam int WORD_W    = NOTE_W + DUR_W;  // ROM word {note, duration}
  localparam int ROM_DEPTH = 1 << ADDR_W;

  // Last note index of a song; reaching it ends the song.
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  // Location of the one zero-duration word in the built-in table (song 2,
  // note 3), used as an end marker when end codes are enabled.
  localparam logic [ADDR_W-1:0] END_MARK_ADDR = {2'd2, 5'd3};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH     = 2'd1,
    WAIT_ROM  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
  } rom_word_t;

  // Built-in song table evaluated at elaboration: note = 3*addr + 12 (mod 64),
  // duration = 8 + addr[2:0], with a single zero-duration word at
  // END_MARK_ADDR. Replace this function to change the song data.
  function automatic rom_word_t rom_init_word(input logic [ADDR_W-1:0] addr);
    rom_word_t w;
    int a;
    a          = int'(addr);
    w.note     = NOTE_W'(a * 3 + 12);
    w.duration = (addr == END_MARK_ADDR) ? '0 : DUR_W'((a % 8) + 8);
    return w;
  endfunction

endpackage

// File: rtl/song_reader_song_rom.sv
// song_rom: synchronous-read note ROM, address {song, idx}, data
// {note, duration}, one cycle of read latency. The read only happens when
// en is high, so the address is sampled at that edge alone.
module song_rom
  import song_reader_pkg::*;
(
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output rom_word_t         data
);

  rom_word_t mem [ROM_DEPTH];

  // Constant contents, filled from the package song table.
  for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_fill
    assign mem[i] = rom_init_word(ADDR_W'(i));
  end

  // Registered read; the consumer only looks at data one cycle after en.
  // NOTE: memory read registers carry no reset so they map onto block-RAM
  // output registers; nothing downstream uses data before the first read.
  always_ff @(posedge clk) begin
    if (en) data <= mem[addr];
  end

endmodule

// File: rtl/song_reader.sv
// song_reader: walks the note ROM for the selected song and hands one
// {note, duration} word at a time to the note player (new_note/note_done
// handshake), pulsing song_done when the song ends.
// Build option: define SONG_READER_END_CODE_EN to treat a zero-duration ROM
// word as an end-of-song marker; by default such a word plays as a note.
module song_reader
  import song_reader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,      // asynchronous, active low
  input  logic              restart,
  input  logic              play,
  input  logic [SONG_W-1:0] song,
  input  logic              note_done,
  output logic [NOTE_W-1:0] note,
  output logic [DUR_W-1:0]  duration,
  output logic              new_note,
  output logic              song_done
);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_en;
  rom_word_t         rom_data;
  logic              end_marker;

  // The song select is only captured by the ROM on the FETCH exit edge.
  assign rom_addr = {song, idx};
  assign rom_en   = (state == FETCH);

`ifdef SONG_READER_END_CODE_EN
  assign end_marker = (rom_data.duration == '0);
`else
  assign end_marker = 1'b0;
`endif

  song_rom u_rom (
    .clk  (clk),
    .en   (rom_en),
    .addr (rom_addr),
    .data (rom_data)
  );

  // Playback FSM, note index counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      idx       <= '0;
      note      <= '0;
      duration  <= '0;
      new_note  <= 1'b0;
      song_done <= 1'b0;
    end else begin
      // NOTE: the pulse outputs default low every cycle and are raised only
      // in the branch that issues them, which keeps them exactly one cycle.
      new_note  <= 1'b0;
      song_done <= 1'b0;
      if (restart) begin
        state <= IDLE;
        idx   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (play) state <= FETCH;
          end
          FETCH: begin
            if (play) state <= WAIT_ROM;
          end
          WAIT_ROM: begin
            if (end_marker) begin
              song_done <= 1'b1;
              idx       <= '0;
              state     <= IDLE;
            end else begin
              note     <= rom_data.note;
              duration <= rom_data.duration;
              new_note <= 1'b1;
              state    <= WAIT_DONE;
            end
          end
          WAIT_DONE: begin
            if (note_done) begin
              if (idx == IDX_MAX) begin
                idx       <= '0;
                song_done <= 1'b1;
                state     <= IDLE;
              end else begin
                idx   <= idx + 1'b1;
                state <= FETCH;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
